// File: rtl/fejkon_identity_pkg.sv
// rtl/fejkon_identity_pkg.sv - shared states, field positions and addresses for the identity probe
package fejkon_identity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_HASH,
    WAIT_HASH,
    DONE
  } state_t;

  localparam int MAGIC_LSB   = 0;
  localparam int MAGIC_W     = 16;
  localparam int VERSION_LSB = 16;
  localparam int VERSION_W   = 8;
  localparam int PORTS_LSB   = 24;
  localparam int PORTS_W     = 8;

  localparam logic ADDR_ID   = 1'b0;
  localparam logic ADDR_HASH = 1'b1;

endpackage

// File: rtl/fejkon_identity_timeout.sv
// rtl/fejkon_identity_timeout.sv - per-transaction cycle counter, hit on the LIMIT-th counted cycle
module fejkon_identity_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // count is 0 in the first cycle of a transaction, so LIMIT-1 marks its last allowed cycle
  assign hit = enable && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/fejkon_identity_probe.sv
// rtl/fejkon_identity_probe.sv - Avalon-MM reader/validator for the fejkon identity words; optional FEJKON_IDENTITY_PROBE_AUTOSTART_EN
module fejkon_identity_probe
  import fejkon_identity_pkg::*;
#(
  parameter logic [15:0] EXPECTED_MAGIC   = 16'h0DE5,
  parameter logic [7:0]  EXPECTED_VERSION = 8'h01,
  parameter int          TIMEOUT_CYCLES   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        mm_address,
  output logic        mm_read,
  input  logic        mm_waitrequest,
  input  logic [31:0] mm_readdata,
  input  logic        mm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic        magic_err,
  output logic        version_err,
  output logic        timeout_err,
  output logic [7:0]  version,
  output logic [7:0]  ports,
  output logic [31:0] git_hash
);

  state_t state, state_next;
  logic   go, in_rd, in_wait, rd_valid, magic_bad, version_bad;
  logic   tmo_hit, tmo_clear, timeout_fire, ok_next;

`ifdef FEJKON_IDENTITY_PROBE_AUTOSTART_EN
  logic armed, arm_dly;

  // arm_dly delays the self-start to the second edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed   <= 1'b1;
      arm_dly <= 1'b0;
    end else begin
      arm_dly <= 1'b1;
      if (armed && arm_dly) armed <= 1'b0;
    end
  end

  assign go = start | (armed & arm_dly);
`else
  assign go = start;
`endif

  assign in_rd       = (state == RD_ID) || (state == RD_HASH);
  assign in_wait     = (state == WAIT_ID) || (state == WAIT_HASH);
  assign rd_valid    = in_wait && mm_readdatavalid;
  assign magic_bad   = mm_readdata[MAGIC_LSB +: MAGIC_W] != EXPECTED_MAGIC;
  assign version_bad = mm_readdata[VERSION_LSB +: VERSION_W] != EXPECTED_VERSION;

  fejkon_identity_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .enable  (in_rd || in_wait),
    .hit     (tmo_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    timeout_fire = 1'b0;
    case (state)
      IDLE, DONE: if (go) state_next = RD_ID;
      RD_ID: begin
        if (tmo_hit)              state_next = DONE;
        else if (!mm_waitrequest) state_next = WAIT_ID;
      end
      WAIT_ID: begin
        if (mm_readdatavalid) state_next = magic_bad ? DONE : RD_HASH;
        else if (tmo_hit)     state_next = DONE;
      end
      RD_HASH: begin
        if (tmo_hit)              state_next = DONE;
        else if (!mm_waitrequest) state_next = WAIT_HASH;
      end
      WAIT_HASH: begin
        if (mm_readdatavalid || tmo_hit) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    // a read completing on the limit cycle beats the timeout
    if ((in_rd && tmo_hit) || (in_wait && tmo_hit && !mm_readdatavalid)) timeout_fire = 1'b1;

    tmo_clear = ((state_next == RD_ID) && (state != RD_ID)) ||
                ((state_next == RD_HASH) && (state != RD_HASH));

    ok_next = ok;
    if (((state == IDLE) || (state == DONE)) && go) begin
      ok_next = 1'b0;
    end else if ((state_next == DONE) && (state != DONE)) begin
      ok_next = !timeout_fire &&
                !((state == WAIT_ID) ? (magic_bad || version_bad) : (magic_err || version_err));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mm_read     <= 1'b0;
      mm_address  <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      ok          <= 1'b0;
      magic_err   <= 1'b0;
      version_err <= 1'b0;
      timeout_err <= 1'b0;
      version     <= '0;
      ports       <= '0;
      git_hash    <= '0;
    end else begin
      mm_read    <= (state_next == RD_ID) || (state_next == RD_HASH);
      mm_address <= (state_next == RD_HASH) ? ADDR_HASH : ADDR_ID;
      busy       <= (state_next != IDLE) && (state_next != DONE);
      done       <= state_next == DONE;
      ok         <= ok_next;
      if (((state == IDLE) || (state == DONE)) && go) begin
        magic_err   <= 1'b0;
        version_err <= 1'b0;
        timeout_err <= 1'b0;
        version     <= '0;
        ports       <= '0;
        git_hash    <= '0;
      end
      if (rd_valid && (state == WAIT_ID)) begin
        version     <= mm_readdata[VERSION_LSB +: VERSION_W];
        ports       <= mm_readdata[PORTS_LSB +: PORTS_W];
        magic_err   <= magic_bad;
        version_err <= version_bad;
      end
      if (rd_valid && (state == WAIT_HASH)) git_hash <= mm_readdata;
      if (timeout_fire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fejkon_identity_probe.sv
// tb/tb_fejkon_identity_probe.sv - table-driven scoreboard bench for the identity probe
module tb_fejkon_identity_probe;

  typedef struct {
    int          done_cyc;
    bit          ok;
    bit          magic_err;
    bit          version_err;
    bit          timeout_err;
    logic [7:0]  version;
    logic [7:0]  ports;
    logic [31:0] hash;
    bit          hash_read;
  } exp_t;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          waits;
    int          lat;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, mm_waitrequest = 1'b0, mm_readdatavalid = 1'b0;
  logic [31:0] mm_readdata = '0;
  logic        mm_address, mm_read, busy, done, ok, magic_err, version_err, timeout_err;
  logic [7:0]  version, ports;
  logic [31:0] git_hash;

  logic        start_t = 1'b0, mm_waitrequest_t = 1'b0, mm_readdatavalid_t = 1'b0;
  logic [31:0] mm_readdata_t = '0;
  logic        mm_address_t, mm_read_t, busy_t, done_t, ok_t, magic_err_t, version_err_t, timeout_err_t;
  logic [7:0]  version_t, ports_t;
  logic [31:0] git_hash_t;

  int   checks = 0;
  int   passes = 0;
  exp_t sbq[$];
  vec_t tbl[4];

  always #5 clk = ~clk;

  fejkon_identity_probe dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mm_address(mm_address), .mm_read(mm_read), .mm_waitrequest(mm_waitrequest),
    .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid),
    .busy(busy), .done(done), .ok(ok), .magic_err(magic_err), .version_err(version_err),
    .timeout_err(timeout_err), .version(version), .ports(ports), .git_hash(git_hash)
  );

  fejkon_identity_probe #(.TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .reset_n(reset_n), .start(start_t),
    .mm_address(mm_address_t), .mm_read(mm_read_t), .mm_waitrequest(mm_waitrequest_t),
    .mm_readdata(mm_readdata_t), .mm_readdatavalid(mm_readdatavalid_t),
    .busy(busy_t), .done(done_t), .ok(ok_t), .magic_err(magic_err_t), .version_err(version_err_t),
    .timeout_err(timeout_err_t), .version(version_t), .ports(ports_t), .git_hash(git_hash_t)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return {mm_read, mm_address, busy, done, ok, magic_err, version_err, timeout_err,
            version, ports, git_hash};
  endfunction

  function automatic logic [63:0] all_outs_t();
    return {mm_read_t, mm_address_t, busy_t, done_t, ok_t, magic_err_t, version_err_t,
            timeout_err_t, version_t, ports_t, git_hash_t};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    exp_t  e;
    resp_t r;
    resp_t rq[$];
    bit    got_done = 0, in_cmd = 0, stable = 1, hash_read = 0;
    int    wl = 0;
    logic  cmd_addr = 1'b0;
    @(negedge clk);
    start = 1'b1;
    sbq.push_back(v.e);
    for (int k = 1; k <= 200 && !got_done; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got_done = 1;
        e = sbq.pop_front();
        chk({tag, " done_cycle"}, 64'(k), 64'(e.done_cyc));
        chk({tag, " ok"}, ok, e.ok);
        chk({tag, " magic_err"}, magic_err, e.magic_err);
        chk({tag, " version_err"}, version_err, e.version_err);
        chk({tag, " timeout_err"}, timeout_err, e.timeout_err);
        chk({tag, " version"}, version, e.version);
        chk({tag, " ports"}, ports, e.ports);
        chk({tag, " git_hash"}, git_hash, e.hash);
        chk({tag, " hash_read"}, hash_read, e.hash_read);
        chk({tag, " cmd_stable"}, stable, 1'b1);
        chk({tag, " busy_idle"}, {busy, mm_read}, 2'b00);
      end else begin
        mm_waitrequest = 1'b0;
        if (mm_read) begin
          if (!in_cmd) begin
            in_cmd   = 1;
            wl       = v.waits;
            cmd_addr = mm_address;
          end else if (mm_address !== cmd_addr) begin
            stable = 0;
          end
          if (mm_address) hash_read = 1;
          if (wl > 0) begin
            mm_waitrequest = 1'b1;
            wl--;
          end else begin
            in_cmd = 0;
            r.due  = k + v.lat;
            r.d    = mm_address ? v.w1 : v.w0;
            rq.push_back(r);
          end
        end else if (in_cmd) begin
          stable = 0;
        end
        if (rq.size() > 0 && rq[0].due == k) begin
          mm_readdatavalid = 1'b1;
          mm_readdata      = rq[0].d;
          void'(rq.pop_front());
        end else begin
          mm_readdatavalid = 1'b0;
          mm_readdata      = $urandom;
        end
      end
    end
    if (!got_done) begin
      chk({tag, " done_within_budget"}, 1'b0, 1'b1);
      void'(sbq.pop_front());
    end
    mm_waitrequest   = 1'b0;
    mm_readdatavalid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h01010DE5, 32'hDEADBEEF, 0, 1,
               '{5, 1, 0, 0, 0, 8'h01, 8'h01, 32'hDEADBEEF, 1}};
    tbl[1] = '{32'h01011234, 32'hCAFEF00D, 0, 1,
               '{3, 0, 1, 0, 0, 8'h01, 8'h01, 32'h0, 0}};
    tbl[2] = '{32'h01020DE5, 32'h12345678, 0, 1,
               '{5, 0, 0, 1, 0, 8'h02, 8'h01, 32'h12345678, 1}};
    tbl[3] = '{32'h04010DE5, 32'hA5A5F00D, 10, 3,
               '{29, 1, 0, 0, 0, 8'h01, 8'h04, 32'hA5A5F00D, 1}};

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    chk("reset_outputs_t", all_outs_t(), 64'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // timeout: word-0 command accepted, data never returns
    @(negedge clk);
    start_t = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_t = 1'b0;
      if (k == 8) chk("tmo_before_limit", {busy_t, timeout_err_t, done_t}, 3'b100);
      if (k == 9) chk("tmo_at_limit", {mm_read_t, busy_t, done_t, ok_t, timeout_err_t}, 5'b00101);
      mm_readdatavalid_t = (k == 10);
      mm_readdata_t      = (k == 10) ? 32'h01010DE5 : 32'h0;
      if (k == 11) chk("tmo_late_valid_ignored",
                       {done_t, timeout_err_t, magic_err_t, version_t, ports_t}, {2'b11, 1'b0, 16'h0});
    end
    mm_readdatavalid_t = 1'b0;

    // reset during WAIT_HASH
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start            = 1'b0;
      mm_readdatavalid = (k == 2);
      mm_readdata      = 32'h01010DE5;
      if (k == 4) chk("rst_pre_wait_hash", {busy, mm_read, version}, {2'b10, 8'h01});
    end
    mm_readdatavalid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_async_clear", all_outs(), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mm_readdatavalid = 1'b1;
    mm_readdata      = 32'hDEADBEEF;
    @(negedge clk);
    mm_readdatavalid = 1'b0;
    chk("rst_late_valid_ignored", all_outs(), 64'h0);
    run_vec(tbl[0], "after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
